ssd_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It drives one shared BCD-to-segment decoder (4-bit BCD in, active-low segments out) by sequencing digit selects and presenting the matching nibble each scan slot. New display values are accepted through a valid/ready handshake into a shadow buffer and committed only at a frame boundary, so a displayed value never tears. It sits between the application logic (counters, note/frequency readouts) and the board's segment/anode pins.

---
 rtl/ssd_scan_if.sv | 21 ++
 rtl/ssd_scan_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/ssd_scan_if.sv
// Load handshake and display pin bundle between application logic and ssd_scan_ctrl.
// The master side supplies display values; the slave side (the scan controller) drives the pins.
interface ssd_scan_if;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        blank;
    logic [3:0]  digit_bcd;
    logic [3:0]  ssd_ctl;
    logic        frame_end;

    modport master (
        output load_data, load_valid, blank,
        input  load_ready, digit_bcd, ssd_ctl, frame_end
    );

    modport slave (
        input  load_data, load_valid, blank,
        output load_ready, digit_bcd, ssd_ctl, frame_end
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// 4-digit common-anode scan controller with a shadow buffer that is committed at frame end.
// Optional leading-zero blanking is compiled in when SSD_LZB_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SH_EMPTY | shadow buffer free, load_ready high
// SH_FULL  | shadow holds a value waiting for the next frame boundary
module ssd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input logic        clk,
    input logic        rst,
    ssd_scan_if.slave  bus
);
    typedef enum logic {SH_EMPTY, SH_FULL} shadow_state_t;

    shadow_state_t sh_state, sh_next;
    logic [16:0]   slot_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   active_buf;
    logic [15:0]   shadow_buf;
    logic [3:0]    ssd_ctl_q;
    logic [3:0]    digit_bcd_q;
    logic          slot_wrap;
    logic          commit;
    logic          load_acc;
    logic [3:0]    nib_sel;
    logic [3:0]    nib_out;

    assign slot_wrap = (slot_cnt == 17'(SCAN_DIV - 1));
    assign commit    = slot_wrap && (digit_idx == 2'd3);
    assign load_acc  = bus.load_valid && (sh_state == SH_EMPTY);

    assign bus.load_ready = (sh_state == SH_EMPTY);
    assign bus.frame_end  = commit;
    assign bus.ssd_ctl    = ssd_ctl_q;
    assign bus.digit_bcd  = digit_bcd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_state <= SH_EMPTY;
        end else begin
            sh_state <= sh_next;
        end
    end

    // A load landing on the commit cycle of an empty shadow is held for the next frame.
    always_comb begin
        sh_next = sh_state;
        unique case (sh_state)
            SH_EMPTY: if (load_acc) sh_next = SH_FULL;
            SH_FULL:  if (commit)   sh_next = SH_EMPTY;
            default:                sh_next = SH_EMPTY;
        endcase
    end

    always_comb begin
        nib_sel = 4'hF;
        unique case (digit_idx)
            2'd0: nib_sel = active_buf[3:0];
            2'd1: nib_sel = active_buf[7:4];
            2'd2: nib_sel = active_buf[11:8];
            2'd3: nib_sel = active_buf[15:12];
            default: nib_sel = 4'hF;
        endcase
    end

`ifdef SSD_LZB_EN
    logic lead_zero;

    // Digit 0 is never blanked so an all-zero value still reads "0".
    always_comb begin
        lead_zero = 1'b0;
        unique case (digit_idx)
            2'd3: lead_zero = (active_buf[15:12] == 4'h0);
            2'd2: lead_zero = (active_buf[15:8] == 8'h00);
            2'd1: lead_zero = (active_buf[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        nib_out = lead_zero ? 4'hF : nib_sel;
    end
`else
    assign nib_out = nib_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit_idx   <= 2'd0;
            active_buf  <= 16'hFFFF;
            shadow_buf  <= 16'hFFFF;
            ssd_ctl_q   <= 4'b1111;
            digit_bcd_q <= 4'hF;
        end else begin
            slot_cnt <= slot_wrap ? 17'd0 : slot_cnt + 17'd1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (load_acc) begin
                shadow_buf <= bus.load_data;
            end
            if (commit && (sh_state == SH_FULL)) begin
                active_buf <= shadow_buf;
            end
            ssd_ctl_q   <= bus.blank ? 4'b1111 : 4'(~(4'b0001 << digit_idx));
            digit_bcd_q <= bus.blank ? 4'hF : nib_out;
        end
    end
endmodule
